// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one registered adder among N requesters.
// One operation in flight: accept, issue start pulse, wait for result (or timeout), respond.
module adder_share_arbiter #(
    parameter int W       = 10,
    parameter int N       = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         req_ready,
    output logic                 add_start,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_y,
    input  logic                 add_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_err
);

    localparam int IW = $clog2(N);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          add_start_q, add_start_d;
    logic [W-1:0]  add_a_q, add_a_d;
    logic [W-1:0]  add_b_q, add_b_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]  rsp_sum_q, rsp_sum_d;
    logic          rsp_err_q, rsp_err_d;

    logic [N-1:0]  grant_s;
    logic          found_s;
    logic [IW-1:0] win_s;
    logic [PW-1:0] idx_s;
    logic [PW-1:0] nxt_s;
    logic [W-1:0]  a_arr_s [N];
    logic [W-1:0]  b_arr_s [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr_s[i] = req_a[i*W +: W];
        assign b_arr_s[i] = req_b[i*W +: W];
    end

    // Round-robin search starting at ptr; idx wraps without a modulo operator.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_q} + PW'(k);
            if (idx_s >= PW'(N)) begin
                idx_s = idx_s - PW'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[IW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant_s[win_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        nxt_s = {1'b0, win_s} + PW'(1);
    end

    // Grant is only offered in IDLE and is suppressed while reset is held.
    assign req_ready = (state_q == S_IDLE && rst_n) ? grant_s : '0;

    // Sequencer next-state and datapath.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        add_start_d = add_start_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    add_a_d     = a_arr_s[win_s];
                    add_b_d     = b_arr_s[win_s];
                    add_start_d = 1'b1;
                    rsp_id_d    = win_s;
                    ptr_d       = (nxt_s == PW'(N)) ? '0 : nxt_s[IW-1:0];
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                add_start_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (add_valid) begin
                    rsp_sum_d   = add_y;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d       = CW'(TIMEOUT);
                    rsp_sum_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            add_start_q <= add_start_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;

endmodule
